// File: rtl/gray_pattern_source.sv
// Synthetic 12-bit grayscale frame generator with line/frame framing, used in
// place of the camera front end so downstream edge filters see known frames.
module gray_pattern_source #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned H_BLANK   = 32,
  parameter int unsigned V_BLANK   = 4,
  parameter int unsigned BAR_SHIFT = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEnable,
  input  logic [1:0]  iMode,
  input  logic [11:0] iLevel,
  output logic [11:0] oGray,
  output logic        oDVAL,
  output logic        oLVAL,
  output logic        oFVAL,
  output logic [10:0] oX,
  output logic [10:0] oY,
  output logic        oFrameDone
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_e;

  localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST  = 11'(V_ACTIVE - 1);
  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [11:0] level_q, level_d;
  logic        done_d;

  logic [11:0] gray_q;
  logic        dval_q;
  logic        fval_q;
  logic        done_q;

  function automatic logic [11:0] pattern_f(input logic [1:0]  mode,
                                            input logic [11:0] level,
                                            input logic [10:0] x,
                                            input logic [10:0] y);
    logic [11:0] g;
    g = level;
    case (mode)
      2'd0: g = level;
      2'd1: g = y[BAR_SHIFT] ? 12'hFFF : 12'h000;
      2'd2: g = {y[8:0], 3'b000};
      2'd3: g = (x[BAR_SHIFT] ^ y[BAR_SHIFT]) ? 12'hFFF : 12'h000;
    endcase
    return g;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    level_d = level_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iEnable) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          mode_d  = iMode;
          level_d = iLevel;
        end
      end
      S_ACTIVE: begin
        if (x_q == X_LAST) begin
          state_d = S_HBLANK;
          cnt_d   = '0;
        end else begin
          x_d = x_q + 11'd1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          if (y_q != Y_LAST) begin
            state_d = S_ACTIVE;
            x_d     = '0;
            y_d     = y_q + 11'd1;
          end else begin
            state_d = S_VBLANK;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_VBLANK: begin
        if (cnt_q == VB_LAST) begin
          // Frame boundary: the only point where enable, mode and level are sampled.
          x_d = '0;
          y_d = '0;
          if (iEnable) begin
            state_d = S_ACTIVE;
            mode_d  = iMode;
            level_d = iLevel;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so the first pixel
  // appears right after the edge that samples iEnable.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      level_q <= '0;
      gray_q  <= '0;
      dval_q  <= 1'b0;
      fval_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      level_q <= level_d;
      dval_q  <= (state_d == S_ACTIVE);
      fval_q  <= (state_d == S_ACTIVE) || (state_d == S_HBLANK);
      gray_q  <= (state_d == S_ACTIVE) ? pattern_f(mode_d, level_d, x_d, y_d) : 12'h000;
      done_q  <= done_d;
    end
  end

  assign oGray      = gray_q;
  assign oDVAL      = dval_q;
  assign oLVAL      = dval_q;
  assign oFVAL      = fval_q;
  assign oX         = x_q;
  assign oY         = y_q;
  assign oFrameDone = done_q;

endmodule
